// File: rtl/spi_master_transmit.sv
// -----------------------------------------------------------------------------
// spi_master_transmit
//
// Transmit end of the keyboard's serial sample link. 8-bit samples arrive over
// a valid/ready handshake and are queued in a small FIFO. Each sample is then
// shifted out MSB-first on sck/sdi to a receive-only shift-register slave,
// which samples sdi on every rising sck. sck idles low.
//
// Parameters
//   CLK_DIV    : sck half-period in clk cycles (>= 1)
//   FIFO_DEPTH : input FIFO entries (power of two, >= 2)
//
// Ports
//   clk    in   system clock, all state updates on the rising edge
//   reset  in   asynchronous, active-high; clears all state immediately
//   data   in   [7:0] sample to transmit
//   valid  in   data is offered this cycle
//   ready  out  FIFO can accept (registered count < FIFO_DEPTH)
//   sck    out  serial clock, idles low
//   sdi    out  serial data to the slave, MSB first
//   done   out  one-cycle pulse after a byte's final sck falling edge
//   busy   out  FSM not IDLE or FIFO non-empty
// -----------------------------------------------------------------------------
module spi_master_transmit #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       sck,
    output logic       sdi,
    output logic       done,
    output logic       busy
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nx;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_nx;

    logic [DIV_W-1:0] div_cnt, div_cnt_nx;
    logic [3:0]       bit_cnt, bit_cnt_nx;
    logic [7:0]       shreg, shreg_nx;
    logic             sck_nx, sdi_nx, done_nx;
    logic             push, pop;

    // ready comes straight from the registered count, so a pop on the same
    // edge never frees room for a push into a full FIFO.
    assign push = valid & ready;

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so no
        // path through the case statement leaves one unassigned (no latches).
        state_nx   = state;
        div_cnt_nx = div_cnt;
        bit_cnt_nx = bit_cnt;
        shreg_nx   = shreg;
        sck_nx     = sck;
        sdi_nx     = sdi;
        done_nx    = 1'b0;
        pop        = 1'b0;

        case (state)
            // DONE behaves exactly like IDLE for the next pop, which is what
            // gives the 16*CLK_DIV+1 back-to-back frame period.
            IDLE, DONE: begin
                sck_nx   = 1'b0;
                sdi_nx   = 1'b0;
                state_nx = IDLE;
                if (count != '0) begin
                    pop        = 1'b1;
                    shreg_nx   = fifo_mem[rd_ptr];
                    sdi_nx     = fifo_mem[rd_ptr][7];
                    div_cnt_nx = '0;
                    bit_cnt_nx = '0;
                    state_nx   = SHIFT;
                end
            end

            SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_nx = '0;
                    sck_nx     = ~sck;
                    // sdi only moves on the falling toggle, so it is stable for
                    // a full half-period either side of the rising edge.
                    if (sck) begin
                        bit_cnt_nx = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            sck_nx   = 1'b0;
                            sdi_nx   = 1'b0;
                            done_nx  = 1'b1;
                            state_nx = DONE;
                        end else begin
                            shreg_nx = {shreg[6:0], 1'b0};
                            sdi_nx   = shreg[6];
                        end
                    end
                end else begin
                    div_cnt_nx = div_cnt + DIV_W'(1);
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        count_nx = count;
        case ({push, pop})
            2'b10:   count_nx = count + CNT_W'(1);
            2'b01:   count_nx = count - CNT_W'(1);
            default: count_nx = count;
        endcase
    end

    // NOTE: the FIFO storage has no reset; an entry is only ever read after it
    // has been written, and leaving it out keeps the array a plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            sck     <= 1'b0;
            sdi     <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            ready   <= 1'b1;
        end else begin
            state   <= state_nx;
            count   <= count_nx;
            div_cnt <= div_cnt_nx;
            bit_cnt <= bit_cnt_nx;
            shreg   <= shreg_nx;
            sck     <= sck_nx;
            sdi     <= sdi_nx;
            done    <= done_nx;
            busy    <= (state_nx != IDLE) || (count_nx != '0);
            ready   <= (count_nx != COUNT_FULL);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: doc/spi_master_transmit.md
# spi_master_transmit

Transmitting end of the keyboard's serial sample link. It accepts 8-bit samples over a valid/ready handshake into a small FIFO. It then serializes each sample MSB-first on `sck`/`sdi` for the receive-only shift-register slave, which samples `sdi` on every rising `sck`. It sits between the sample/envelope source and the SPI pins, and pulses `done` once per completed byte.

## Interface
- `CLK_DIV`, 4: `sck` half-period in `clk` cycles; legal range ≥1.
- `FIFO_DEPTH`, 4: input FIFO entries; power of two, ≥2.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `data`  in  8  sample to transmit.
- `valid`  in  1  `data` is offered this cycle.
- `ready`  out  1  FIFO can accept; high when FIFO count < FIFO_DEPTH.
- `sck`  out  1  serial clock; idles low.
- `sdi`  out  1  serial data to slave, MSB first.
- `done`  out  1  one-cycle pulse after a byte's final `sck` falling edge.
- `busy`  out  1  high when FSM not IDLE or FIFO non-empty.

## Operation
- Push: `valid & ready` at a rising edge writes `data` to the FIFO tail. `valid & ~ready` is ignored; the data is dropped and no error is flagged.
- `ready` depends only on the registered count, with no pop pass-through. When the FIFO is full, a push is refused even if a pop occurs on the same edge.
- A simultaneous push and pop on a non-full FIFO leaves the count unchanged and keeps order intact.
- FSM states:
  - IDLE: `sck`=0, `sdi`=0. If FIFO non-empty: pop head into an 8-bit shift register, drive `sdi`=bit7, clear the divider and bit counters, and go to SHIFT.
  - SHIFT: the divider counts 0..CLK_DIV-1 and toggles `sck` at terminal count.
    - On a low→high toggle, the slave samples; `sdi` does not change.
    - On a high→low toggle, the bit counter increments. If fewer than 8 bits are done, the register shifts left and `sdi` takes the new bit7.
    - After the 8th falling toggle, `sck`=0, `sdi`=0, and the FSM goes to DONE.
  - DONE: `done`=1 for exactly this cycle. If FIFO non-empty, pop and go straight to SHIFT, exactly as from IDLE. Otherwise go to IDLE.
- Bit order: MSB first. After 8 rising edges the slave register holds the byte exactly.
- Widths:
  - Divider counter is ceil(log2(CLK_DIV)) bits, minimum 1.
  - Bit counter is 4 bits, so it reaches 8 without wrap.
  - FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - Count is log2(FIFO_DEPTH)+1 bits.
- All outputs are registered; there are no combinational paths from `valid`/`data` to outputs.

## Timing
- Reset values: `sck`=0, `sdi`=0, `done`=0, `busy`=0, `ready`=1; FIFO empty, FSM IDLE, all counters 0.
- Reset is asserted asynchronously. Any in-flight frame is abandoned without completing, FIFO contents are flushed, and no `done` is issued.
- Latency, with push at edge T into an empty FIFO with FSM IDLE:
  - T+1: SHIFT entered, `sdi`=bit7.
  - First `sck` rise at T+1+CLK_DIV.
  - k-th rise at T+1+(2k-1)·CLK_DIV.
  - Final fall at T+1+16·CLK_DIV, which enters DONE.
  - `done` is high in the cycle following that edge.
- Each bit is stable for 2·CLK_DIV cycles, centred on its rising `sck`. Setup and hold are each CLK_DIV cycles.
- Back-to-back frame period is 16·CLK_DIV+1 cycles: one DONE cycle with `sck` low between bytes.
- `busy` falls on the edge the FSM enters IDLE with the FIFO empty.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle → `sck`=0, `sdi`=0, `done`=0, `busy`=0, `ready`=1 immediately. No `sck` edges occur for 100 cycles with `valid`=0.
- Single byte 0xA5, CLK_DIV=4, push at edge T:
  - `sdi` at successive `sck` rises is 1,0,1,0,0,1,0,1.
  - Rises occur at T+5, T+13, …, T+61.
  - `done` is high for the one cycle after edge T+65.
  - A slave model holds 0xA5.
- FIFO full: push 0x01,0x80,0xFF,0x00,0x3C,0x99 on 6 consecutive edges T..T+5.
  - First five are accepted; `ready`=0 after edge T+4; 0x99 is dropped.
  - Slave receives 0x01,0x80,0xFF,0x00,0x3C in order.
  - `done` pulses are spaced 65 cycles apart.
- Simultaneous push and pop: keep the FIFO at 3 entries and push exactly on the DONE→SHIFT edge → count unchanged, no byte lost or duplicated across 10 frames.
- Reset mid-frame: after the 3rd rise of byte 0xF0 (2 more queued), pulse `reset` → `sck` low at once, no `done`, `busy`=0, `ready`=1. A subsequent push of 0x5A transmits correctly with the original latency.
- CLK_DIV=1 with 0xC3 → `sck` toggles every `clk`. Frame is 17 cycles from SHIFT entry to DONE exit inclusive. Slave holds 0xC3.
